// File: rtl/glyph_pkg.sv
// Shared constants and types for the glyph raster reader and its scan counter.
package glyph_pkg;

    localparam int unsigned GLYPH_W = 25;
    localparam int unsigned GLYPH_H = 25;
    // Must hold GLYPH_W*4-1 = 99.
    localparam int unsigned COORD_W = 7;
    localparam int unsigned COL_W   = $clog2(GLYPH_W);
    localparam int unsigned ROW_W   = $clog2(GLYPH_H);

    localparam logic INK = 1'b0;

    // Index 0 is the top row; bit [GLYPH_W-1] of a row is its leftmost column.
    typedef logic [0:GLYPH_H-1][GLYPH_W-1:0] glyph_t;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } glyph_rd_state_t;

endpackage

// File: rtl/glyph_raster_reader_if.sv
// Load and pixel handshake bundle between a glyph source, the reader and the compositor.
interface glyph_raster_reader_if;
    import glyph_pkg::*;

    glyph_t               glyph_in;
    logic [1:0]           scale_in;
    logic                 load_valid;
    logic                 load_ready;
    logic                 abort;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 pix_ink;
    logic [COORD_W-1:0]   pix_x;
    logic [COORD_W-1:0]   pix_y;
    logic                 pix_eol;
    logic                 pix_last;
    logic                 done;

    modport master (
        output glyph_in,
        output scale_in,
        output load_valid,
        input  load_ready,
        output abort,
        input  pix_valid,
        output pix_ready,
        input  pix_ink,
        input  pix_x,
        input  pix_y,
        input  pix_eol,
        input  pix_last,
        input  done
    );

    modport slave (
        input  glyph_in,
        input  scale_in,
        input  load_valid,
        output load_ready,
        input  abort,
        output pix_valid,
        input  pix_ready,
        output pix_ink,
        output pix_x,
        output pix_y,
        output pix_eol,
        output pix_last,
        output done
    );

endinterface

// File: rtl/glyph_scan_counter.sv
// Nested column-repeat / column / row-repeat / row counters walking a scaled glyph row-major.
module glyph_scan_counter
    import glyph_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [1:0]       scale,
    output logic [ROW_W-1:0] row,
    output logic [1:0]       row_rep,
    output logic [COL_W-1:0] col,
    output logic [1:0]       col_rep,
    output logic             eol,
    output logic             last
);

    logic [ROW_W-1:0] row_q, row_d;
    logic [1:0]       row_rep_q, row_rep_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [1:0]       col_rep_q, col_rep_d;

    logic col_rep_end, col_end, row_rep_end, row_end;

    // scale holds S-1, so a repeat counter ends when it equals scale.
    assign col_rep_end = (col_rep_q == scale);
    assign col_end     = (col_q == COL_W'(GLYPH_W - 1));
    assign row_rep_end = (row_rep_q == scale);
    assign row_end     = (row_q == ROW_W'(GLYPH_H - 1));

    assign eol  = col_end & col_rep_end;
    assign last = eol & row_rep_end & row_end;

    always_comb begin
        row_d     = row_q;
        row_rep_d = row_rep_q;
        col_d     = col_q;
        col_rep_d = col_rep_q;
        if (clear) begin
            row_d     = '0;
            row_rep_d = '0;
            col_d     = '0;
            col_rep_d = '0;
        end else if (en) begin
            if (!col_rep_end) begin
                col_rep_d = col_rep_q + 2'd1;
            end else begin
                col_rep_d = '0;
                if (!col_end) begin
                    col_d = col_q + COL_W'(1);
                end else begin
                    col_d = '0;
                    if (!row_rep_end) begin
                        row_rep_d = row_rep_q + 2'd1;
                    end else begin
                        row_rep_d = '0;
                        row_d     = row_end ? '0 : row_q + ROW_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q     <= '0;
            row_rep_q <= '0;
            col_q     <= '0;
            col_rep_q <= '0;
        end else begin
            row_q     <= row_d;
            row_rep_q <= row_rep_d;
            col_q     <= col_d;
            col_rep_q <= col_rep_d;
        end
    end

    assign row     = row_q;
    assign row_rep = row_rep_q;
    assign col     = col_q;
    assign col_rep = col_rep_q;

endmodule

// File: rtl/glyph_raster_reader.sv
// Captures a 25x25 glyph on a load handshake and streams it as scaled, row-major pixels.
module glyph_raster_reader
    import glyph_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    glyph_raster_reader_if.slave  bus
);

    glyph_rd_state_t state_q, state_d;
    glyph_t          buf_q;
    logic [1:0]      scale_q;

    logic             streaming;
    logic             load_hs;
    logic             pix_hs;
    logic [ROW_W-1:0] row;
    logic [1:0]       row_rep;
    logic [COL_W-1:0] col;
    logic [1:0]       col_rep;
    logic             eol;
    logic             last;

    assign streaming = (state_q == STREAM);
    assign load_hs   = bus.load_valid && (state_q == IDLE);
    assign pix_hs    = streaming && bus.pix_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load_hs) state_d = STREAM;
            // abort wins even when it coincides with the final handshake
            STREAM: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (pix_hs && last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            buf_q   <= '1;
            scale_q <= '0;
        end else begin
            state_q <= state_d;
            if (load_hs) begin
                buf_q   <= bus.glyph_in;
                scale_q <= bus.scale_in;
            end
        end
    end

    // Counters are held clear while idle so every accepted glyph starts at (0,0).
    glyph_scan_counter u_scan (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q == IDLE),
        .en      (pix_hs),
        .scale   (scale_q),
        .row     (row),
        .row_rep (row_rep),
        .col     (col),
        .col_rep (col_rep),
        .eol     (eol),
        .last    (last)
    );

    logic [2:0]         scale_n;
    logic [COL_W-1:0]   col_bit;
    logic [COORD_W-1:0] x_raw;
    logic [COORD_W-1:0] y_raw;
    logic               ink_raw;

    assign scale_n = {1'b0, scale_q} + 3'd1;
    assign col_bit = COL_W'(GLYPH_W - 1) - col;
    assign x_raw   = COORD_W'(col) * COORD_W'(scale_n) + COORD_W'(col_rep);
    assign y_raw   = COORD_W'(row) * COORD_W'(scale_n) + COORD_W'(row_rep);
    assign ink_raw = (buf_q[row][col_bit] == INK);

    // Pixel fields read as zero outside STREAM so idle/done match the reset picture.
    assign bus.load_ready = (state_q == IDLE);
    assign bus.pix_valid  = streaming;
    assign bus.pix_ink    = streaming & ink_raw;
    assign bus.pix_x      = streaming ? x_raw : '0;
    assign bus.pix_y      = streaming ? y_raw : '0;
    assign bus.pix_eol    = streaming & eol;
    assign bus.pix_last   = streaming & last;
    assign bus.done       = (state_q == DONE);

endmodule

// File: tb/tb_glyph_raster_reader.sv
// Scoreboard bench for glyph_raster_reader: stimulus queues expected pixels, a monitor checks them.
module tb_glyph_raster_reader;
    import glyph_pkg::*;

    localparam int W = int'(GLYPH_W);
    localparam int H = int'(GLYPH_H);

    typedef struct packed {
        logic               ink;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               eol;
        logic               last;
    } pix_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    glyph_raster_reader_if bus ();

    glyph_raster_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    pix_t   exp_q[$];
    int     total = 0;
    int     bad = 0;
    int     hs_cnt, ink_cnt, eol_cnt, last_cnt, acc_cnt, stall_cnt;
    int     ink_xmin, ink_xmax, ink_ymin, ink_ymax, last_x, last_y;
    bit     stall_mode = 1'b0;
    bit     hold_valid = 1'b0;
    bit     expect_done = 1'b0;
    pix_t   hold_pix, mon_pix, exp_pix;
    glyph_t glyph_a, glyph_b;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic check_pix(input string name, input pix_t act, input pix_t req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s #%0d: got ink=%0b x=%0d y=%0d eol=%0b last=%0b, want ink=%0b x=%0d y=%0d eol=%0b last=%0b",
                     name, hs_cnt, act.ink, act.x, act.y, act.eol, act.last,
                     req.ink, req.x, req.y, req.eol, req.last);
        end
    endtask

    function automatic void push_expected(input glyph_t g, input int s);
        pix_t             p;
        logic [GLYPH_W-1:0] rowv;
        for (int y = 0; y < H * s; y++) begin
            rowv = g[ROW_W'(y / s)];
            for (int x = 0; x < W * s; x++) begin
                p.ink  = (rowv[COL_W'(W - 1 - x / s)] == INK);
                p.x    = COORD_W'(x);
                p.y    = COORD_W'(y);
                p.eol  = (x == W * s - 1);
                p.last = (x == W * s - 1) && (y == H * s - 1);
                exp_q.push_back(p);
            end
        end
    endfunction

    task automatic reset_stats();
        hs_cnt = 0; ink_cnt = 0; eol_cnt = 0; last_cnt = 0; stall_cnt = 0;
        ink_xmin = 1000; ink_xmax = -1; ink_ymin = 1000; ink_ymax = -1;
        last_x = -1; last_y = -1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_load_ready"}, int'(bus.load_ready), 1);
        check({tag, "_pix_valid"},  int'(bus.pix_valid), 0);
        check({tag, "_pix_ink"},    int'(bus.pix_ink), 0);
        check({tag, "_pix_x"},      int'(bus.pix_x), 0);
        check({tag, "_pix_y"},      int'(bus.pix_y), 0);
        check({tag, "_pix_eol"},    int'(bus.pix_eol), 0);
        check({tag, "_pix_last"},   int'(bus.pix_last), 0);
        check({tag, "_done"},       int'(bus.done), 0);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic load(input glyph_t g, input logic [1:0] sc, input bit keep_valid);
        bit ok = 1'b0;
        bus.glyph_in   = g;
        bus.scale_in   = sc;
        bus.load_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.load_ready;
        end
        check("load_ready_seen", int'(ok), 1);
        @(posedge clk); #1;
        push_expected(g, int'(sc) + 1);
        if (!keep_valid) bus.load_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit drop_load);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (drop_load) bus.load_valid = 1'b0;
        check("stream_drained", int'(exp_q.size() == 0), 1);
        exp_q.delete();
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("back_to_idle", int'(bus.load_ready), 1);
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_cnt < target && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("hs_target_reached", int'(hs_cnt == target), 1);
    endtask

    always @(posedge clk) begin
        #1;
        bus.pix_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        mon_pix = {bus.pix_ink, bus.pix_x, bus.pix_y, bus.pix_eol, bus.pix_last};
        if (reset) begin
            hold_valid  = 1'b0;
            expect_done = 1'b0;
        end else begin
            if (expect_done || bus.done) check("done_pulse", int'(bus.done), int'(expect_done));
            expect_done = 1'b0;
            if (bus.load_valid && bus.load_ready) acc_cnt++;
            if (bus.pix_valid) begin
                if (hold_valid) check_pix("stall_hold", mon_pix, hold_pix);
                if (bus.pix_ready) begin
                    hold_valid = 1'b0;
                    hs_cnt++;
                    if (mon_pix.ink) begin
                        ink_cnt++;
                        if (int'(mon_pix.x) < ink_xmin) ink_xmin = int'(mon_pix.x);
                        if (int'(mon_pix.x) > ink_xmax) ink_xmax = int'(mon_pix.x);
                        if (int'(mon_pix.y) < ink_ymin) ink_ymin = int'(mon_pix.y);
                        if (int'(mon_pix.y) > ink_ymax) ink_ymax = int'(mon_pix.y);
                    end
                    if (mon_pix.eol) eol_cnt++;
                    if (mon_pix.last) begin
                        last_cnt++;
                        last_x = int'(mon_pix.x);
                        last_y = int'(mon_pix.y);
                        expect_done = 1'b1;
                    end
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_pixel #%0d: got x=%0d y=%0d, want none",
                                 hs_cnt, mon_pix.x, mon_pix.y);
                    end else begin
                        exp_pix = exp_q.pop_front();
                        check_pix("pixel", mon_pix, exp_pix);
                    end
                end else begin
                    stall_cnt++;
                    hold_valid = 1'b1;
                    hold_pix   = mon_pix;
                end
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.glyph_in   = '1;
        bus.scale_in   = 2'd0;
        bus.load_valid = 1'b0;
        bus.abort      = 1'b0;
        bus.pix_ready  = 1'b1;
        acc_cnt        = 0;
        reset_stats();

        glyph_a = '1;
        glyph_a[3][GLYPH_W - 2] = INK;
        glyph_b = '1;
        glyph_b[0] = '0;
        for (int r = 0; r < H; r++) glyph_b[ROW_W'(r)][COL_W'(W - 1 - r)] = INK;

        #1 reset = 1'b1;
        #1 check_idle("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle("after_reset");

        // Asynchronous reset in the middle of a stream.
        reset_stats();
        load(glyph_a, 2'd0, 1'b0);
        wait_hs(40);
        #2 reset = 1'b1;
        #1 check_idle("midstream_reset");
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_idle("midstream_release");

        // 1x glyph, single ink pixel at column 1, row 3.
        reset_stats();
        load(glyph_a, 2'd0, 1'b0);
        wait_done(2000, 1'b0);
        check("x1_count", hs_cnt, 625);
        check("x1_ink_count", ink_cnt, 1);
        check("x1_ink_x", ink_xmin, 1);
        check("x1_ink_y", ink_ymin, 3);
        check("x1_eol_count", eol_cnt, 25);
        check("x1_last_count", last_cnt, 1);
        check("x1_last_x", last_x, 24);

        // Same glyph at 2x.
        reset_stats();
        load(glyph_a, 2'd1, 1'b0);
        wait_done(4000, 1'b0);
        check("x2_count", hs_cnt, 2500);
        check("x2_ink_count", ink_cnt, 4);
        check("x2_ink_xmin", ink_xmin, 2);
        check("x2_ink_xmax", ink_xmax, 3);
        check("x2_ink_ymin", ink_ymin, 6);
        check("x2_ink_ymax", ink_ymax, 7);
        check("x2_eol_count", eol_cnt, 50);
        check("x2_last_x", last_x, 49);
        check("x2_last_y", last_y, 49);

        // 3x with random backpressure.
        reset_stats();
        stall_mode = 1'b1;
        load(glyph_b, 2'd2, 1'b0);
        wait_done(30000, 1'b0);
        stall_mode = 1'b0;
        check("x3_count", hs_cnt, 5625);
        check("x3_ink_count", ink_cnt, 441);
        check("x3_stalls_seen", int'(stall_cnt > 0), 1);
        check("x3_last_y", last_y, 74);

        // 4x, largest stream.
        reset_stats();
        load(glyph_b, 2'd3, 1'b0);
        wait_done(12000, 1'b0);
        check("x4_count", hs_cnt, 10000);
        check("x4_ink_count", ink_cnt, 784);
        check("x4_last_x", last_x, 99);
        check("x4_last_y", last_y, 99);

        // abort while idle is ignored
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("idle_abort_ready", int'(bus.load_ready), 1);

        // abort coincident with handshake 100, then immediate reload.
        reset_stats();
        load(glyph_a, 2'd0, 1'b0);
        wait_hs(99);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        exp_q.delete();
        check("abort_count", hs_cnt, 100);
        check("abort_valid", int'(bus.pix_valid), 0);
        check("abort_ready", int'(bus.load_ready), 1);
        load(glyph_b, 2'd0, 1'b0);
        check("reload_valid", int'(bus.pix_valid), 1);
        check("reload_x", int'(bus.pix_x), 0);
        check("reload_y", int'(bus.pix_y), 0);
        wait_done(2000, 1'b0);
        check("reload_count", hs_cnt, 725);

        // load_valid held through STREAM/DONE; glyph_in changed mid-stream.
        reset_stats();
        acc_cnt = 0;
        load(glyph_a, 2'd0, 1'b1);
        wait_hs(50);
        bus.glyph_in = '0;
        wait_done(2000, 1'b1);
        check("held_load_accepts", acc_cnt, 1);
        check("held_count", hs_cnt, 625);
        check("held_ink_count", ink_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
